// File: rtl/reg_write_arbiter_if.sv
// Write-request bundle between producers (master) and the register-write arbiter (slave).
// Requester i owns wr_addr[i*AW +: AW] and wr_data[i*WIDTH +: WIDTH].
interface reg_write_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int N_REGS = 4,
  parameter int WIDTH  = 4
);
  localparam int AW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*AW-1:0]    wr_addr;
  logic [N_REQ*WIDTH-1:0] wr_data;
  logic [N_REQ-1:0]       gnt;
  logic [N_REGS-1:0]      reg_en;
  logic [WIDTH-1:0]       reg_d;
  logic                   busy;
  logic                   addr_err;

  modport master (
    output req, wr_addr, wr_data,
    input  gnt, reg_en, reg_d, busy, addr_err
  );

  modport slave (
    input  req, wr_addr, wr_data,
    output gnt, reg_en, reg_d, busy, addr_err
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter giving N_REQ producers one-hot write access to an external
// bank of N_REGS registers; at most one write every two cycles, all outputs registered.
module reg_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int N_REGS = 4,
  parameter int WIDTH  = 4
) (
  input logic                clk,
  input logic                rst,
  reg_write_arbiter_if.slave bus
);
  localparam int AW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_GNT = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REGS-1:0] reg_en_q, reg_en_d;
  logic [WIDTH-1:0]  reg_d_q, reg_d_d;
  logic              busy_q, busy_d;
  logic              addr_err_q, addr_err_d;

  logic [PW-1:0]     scan_idx_s [N_REQ];
  logic              win_found_s;
  logic [PW-1:0]     win_idx_s;
  logic [AW-1:0]     win_addr_s;
  logic [WIDTH-1:0]  win_data_s;
  logic              addr_ok_s;
  logic [N_REGS-1:0] addr_dec_s;
  logic [N_REQ-1:0]  win_onehot_s;

  // Requester indices in round-robin scan order, starting at rr_ptr.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx_s[k] = PW'((int'(rr_ptr_q) + k) % N_REQ);
    end
  end

  // Winner is the first requester in scan order; scanning backwards lets the earliest hit win.
  always_comb begin
    win_found_s = |bus.req;
    win_idx_s   = rr_ptr_q;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      win_idx_s = bus.req[scan_idx_s[k]] ? scan_idx_s[k] : win_idx_s;
    end
  end

  // Select the winner's address/data and decode the target register.
  always_comb begin
    win_addr_s   = '0;
    win_data_s   = '0;
    win_onehot_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      win_onehot_s[k] = (int'(win_idx_s) == k);
      win_addr_s = win_addr_s | (win_onehot_s[k] ? bus.wr_addr[k*AW +: AW] : {AW{1'b0}});
      win_data_s = win_data_s | (win_onehot_s[k] ? bus.wr_data[k*WIDTH +: WIDTH] : {WIDTH{1'b0}});
    end
    addr_ok_s = (int'(win_addr_s) < N_REGS);
    for (int i = 0; i < N_REGS; i++) begin
      addr_dec_s[i] = addr_ok_s && (int'(win_addr_s) == i);
    end
  end

  // State and output registers; reset mid-grant drops the enable without replaying the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ARB;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      reg_en_q   <= '0;
      reg_d_q    <= '0;
      busy_q     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      reg_en_q   <= reg_en_d;
      reg_d_q    <= reg_d_d;
      busy_q     <= busy_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Next-state logic: every grant occupies exactly one GNT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB: begin
        if (win_found_s) begin
          state_d = ST_GNT;
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_GNT:  state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // Output next values; pulses default to 0 and reg_d holds its last value.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = '0;
    reg_en_d   = '0;
    reg_d_d    = reg_d_q;
    busy_d     = 1'b0;
    addr_err_d = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (win_found_s) begin
          gnt_d      = win_onehot_s;
          reg_en_d   = addr_dec_s;
          reg_d_d    = win_data_s;
          busy_d     = 1'b1;
          addr_err_d = ~addr_ok_s;
          rr_ptr_d   = PW'((int'(win_idx_s) + 1) % N_REQ);
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end
      ST_GNT:  rr_ptr_d = rr_ptr_q;
      default: rr_ptr_d = rr_ptr_q;
    endcase
  end

  assign bus.gnt      = gnt_q;
  assign bus.reg_en   = reg_en_q;
  assign bus.reg_d    = reg_d_q;
  assign bus.busy     = busy_q;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: a 4-register instance with a modelled bank,
// plus a 3-register instance for the out-of-range address case.
module tb_reg_write_arbiter;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wr_cnt = 0;
  int   wr3_cnt = 0;
  int   cnt0;
  logic [3:0] bank [4] = '{default: 4'h0};

  reg_write_arbiter_if #(.N_REQ(4), .N_REGS(4), .WIDTH(4)) bus ();
  reg_write_arbiter_if #(.N_REQ(4), .N_REGS(3), .WIDTH(4)) bus3 ();

  reg_write_arbiter #(.N_REQ(4), .N_REGS(4), .WIDTH(4)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  reg_write_arbiter #(.N_REQ(4), .N_REGS(3), .WIDTH(4)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank model plus write counters.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.reg_en[i]) bank[i] <= bus.reg_d;
    end
    if (|bus.reg_en) wr_cnt <= wr_cnt + 1;
    if (|bus3.reg_en) wr3_cnt <= wr3_cnt + 1;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b1111; bus.wr_addr = 8'b11_10_01_00; bus.wr_data = 16'h4321;
    bus3.req = 4'b0000; bus3.wr_addr = 8'h00; bus3.wr_data = 16'h0000;
    for (int c = 0; c < 2; c++) begin
      cyc();
      n_cmp++;
      if (bus.gnt !== 4'b0000 || bus.reg_en !== 4'b0000 || bus.reg_d !== 4'h0 || bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold: gnt=%b en=%b d=%h busy=%b, required all zero", bus.gnt, bus.reg_en, bus.reg_d, bus.busy);
      end
    end
    rst = 1'b0;
    cyc();
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL reset_first_gnt: got %b want 0001", bus.gnt); end
    n_cmp++; if (bus.reg_en !== 4'b0001) begin n_bad++; $display("FAIL reset_first_en: got %b want 0001", bus.reg_en); end
    n_cmp++; if (bus.reg_d !== 4'h1) begin n_bad++; $display("FAIL reset_first_d: got %h want 1", bus.reg_d); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL reset_first_busy: got %b want 1", bus.busy); end
    bus.req = 4'b0000;
    cyc();
    n_cmp++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_after: gnt=%b busy=%b want 0/0", bus.gnt, bus.busy); end
    n_cmp++; if (bank[0] !== 4'h1) begin n_bad++; $display("FAIL reset_bank0: got %h want 1", bank[0]); end
  endtask

  task automatic test_single_write();
    bus.req = 4'b0100; bus.wr_addr = 8'b00_11_00_00; bus.wr_data = 16'h0900;
    cyc();
    n_cmp++; if (bus.gnt !== 4'b0100) begin n_bad++; $display("FAIL single_gnt: got %b want 0100", bus.gnt); end
    n_cmp++; if (bus.reg_en !== 4'b1000) begin n_bad++; $display("FAIL single_en: got %b want 1000", bus.reg_en); end
    n_cmp++; if (bus.reg_d !== 4'h9) begin n_bad++; $display("FAIL single_d: got %h want 9", bus.reg_d); end
    n_cmp++; if (bus.busy !== 1'b1 || bus.addr_err !== 1'b0) begin n_bad++; $display("FAIL single_busy: busy=%b err=%b want 1/0", bus.busy, bus.addr_err); end
    bus.req = 4'b0000;
    cyc();
    n_cmp++; if (bus.gnt !== 4'b0000 || bus.reg_en !== 4'b0000) begin n_bad++; $display("FAIL single_clear: gnt=%b en=%b want 0/0", bus.gnt, bus.reg_en); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_clr: got %b want 0", bus.busy); end
    n_cmp++; if (bus.reg_d !== 4'h9) begin n_bad++; $display("FAIL single_d_hold: got %h want 9", bus.reg_d); end
    n_cmp++; if (bank[3] !== 4'h9) begin n_bad++; $display("FAIL single_bank3: got %h want 9", bank[3]); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    rst = 1'b1; bus.req = 4'b0000;
    cyc();
    rst = 1'b0;
    bus.req = 4'b1111; bus.wr_addr = 8'b11_10_01_00; bus.wr_data = 16'h4321;
    for (int g = 0; g < 5; g++) begin
      exp_oh = 4'b0001 << (g % 4);
      cyc();
      n_cmp++; if (bus.gnt !== exp_oh) begin n_bad++; $display("FAIL rr_gnt%0d: got %b want %b", g, bus.gnt, exp_oh); end
      n_cmp++; if (bus.reg_en !== exp_oh) begin n_bad++; $display("FAIL rr_en%0d: got %b want %b", g, bus.reg_en, exp_oh); end
      n_cmp++; if (bus.reg_d !== 4'((g % 4) + 1)) begin n_bad++; $display("FAIL rr_d%0d: got %h want %0d", g, bus.reg_d, (g % 4) + 1); end
      if (g == 4) bus.req = 4'b0000;
      cyc();
      n_cmp++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rr_gap%0d: gnt=%b busy=%b want 0/0", g, bus.gnt, bus.busy); end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bank[i] !== 4'(i + 1)) begin n_bad++; $display("FAIL rr_bank%0d: got %h want %0d", i, bank[i], i + 1); end
    end
  endtask

  task automatic test_pointer_wrap();
    bus.wr_addr = 8'b01_10_01_10; bus.wr_data = 16'hA325;
    bus.req = 4'b0100;
    cyc();
    n_cmp++; if (bus.gnt !== 4'b0100) begin n_bad++; $display("FAIL wrap_pre_gnt: got %b want 0100", bus.gnt); end
    bus.req = 4'b1001;
    cyc();
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL wrap_gap0: got %b want 0000", bus.gnt); end
    cyc();
    n_cmp++; if (bus.gnt !== 4'b1000) begin n_bad++; $display("FAIL wrap_gnt3: got %b want 1000", bus.gnt); end
    n_cmp++; if (bus.reg_en !== 4'b0010 || bus.reg_d !== 4'hA) begin n_bad++; $display("FAIL wrap_wr3: en=%b d=%h want 0010/a", bus.reg_en, bus.reg_d); end
    bus.req = 4'b0001;
    cyc();
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL wrap_gap1: got %b want 0000", bus.gnt); end
    cyc();
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL wrap_gnt0: got %b want 0001", bus.gnt); end
    n_cmp++; if (bus.reg_en !== 4'b0100 || bus.reg_d !== 4'h5) begin n_bad++; $display("FAIL wrap_wr0: en=%b d=%h want 0100/5", bus.reg_en, bus.reg_d); end
    bus.req = 4'b0000;
    cyc();
    n_cmp++; if (bank[1] !== 4'hA || bank[2] !== 4'h5) begin n_bad++; $display("FAIL wrap_bank: r1=%h r2=%h want a/5", bank[1], bank[2]); end
  endtask

  task automatic test_addr_err();
    int c3;
    bus3.req = 4'b0010; bus3.wr_addr = 8'b00_00_11_00; bus3.wr_data = 16'h00F0;
    cyc();
    c3 = wr3_cnt;
    n_cmp++; if (bus3.gnt !== 4'b0010) begin n_bad++; $display("FAIL aerr_gnt: got %b want 0010", bus3.gnt); end
    n_cmp++; if (bus3.reg_en !== 3'b000) begin n_bad++; $display("FAIL aerr_en: got %b want 000", bus3.reg_en); end
    n_cmp++; if (bus3.addr_err !== 1'b1 || bus3.busy !== 1'b1) begin n_bad++; $display("FAIL aerr_flag: err=%b busy=%b want 1/1", bus3.addr_err, bus3.busy); end
    bus3.req = 4'b0000;
    cyc();
    n_cmp++; if (bus3.addr_err !== 1'b0 || bus3.gnt !== 4'b0000) begin n_bad++; $display("FAIL aerr_clear: err=%b gnt=%b want 0/0000", bus3.addr_err, bus3.gnt); end
    n_cmp++; if (wr3_cnt !== c3) begin n_bad++; $display("FAIL aerr_nowrite: writes=%0d want %0d", wr3_cnt, c3); end
    bus3.req = 4'b0010; bus3.wr_addr = 8'b00_00_10_00;
    cyc();
    n_cmp++; if (bus3.reg_en !== 3'b100 || bus3.addr_err !== 1'b0) begin n_bad++; $display("FAIL aerr_inrange: en=%b err=%b want 100/0", bus3.reg_en, bus3.addr_err); end
    bus3.req = 4'b0000;
    cyc();
  endtask

  task automatic test_reset_in_gnt();
    bus.req = 4'b0001; bus.wr_addr = 8'b00_00_00_01; bus.wr_data = 16'h000C;
    cyc();
    n_cmp++; if (bus.gnt !== 4'b0001 || bus.reg_en !== 4'b0010) begin n_bad++; $display("FAIL rstg_gnt: gnt=%b en=%b want 0001/0010", bus.gnt, bus.reg_en); end
    cnt0 = wr_cnt;
    rst = 1'b1;
    cyc();
    n_cmp++; if (bus.gnt !== 4'b0000 || bus.reg_en !== 4'b0000 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstg_clear: gnt=%b en=%b busy=%b want 0", bus.gnt, bus.reg_en, bus.busy); end
    n_cmp++; if (bus.reg_d !== 4'h0) begin n_bad++; $display("FAIL rstg_d: got %h want 0", bus.reg_d); end
    cyc();
    n_cmp++; if (bus.reg_en !== 4'b0000) begin n_bad++; $display("FAIL rstg_hold_en: got %b want 0000", bus.reg_en); end
    n_cmp++; if (wr_cnt !== cnt0 + 1) begin n_bad++; $display("FAIL rstg_once: writes=%0d want %0d", wr_cnt, cnt0 + 1); end
    n_cmp++; if (bank[1] !== 4'hC) begin n_bad++; $display("FAIL rstg_bank1: got %h want c", bank[1]); end
    rst = 1'b0;
    cyc();
    n_cmp++; if (bus.gnt !== 4'b0001 || bus.reg_en !== 4'b0010) begin n_bad++; $display("FAIL rstg_regnt: gnt=%b en=%b want 0001/0010", bus.gnt, bus.reg_en); end
    bus.req = 4'b0000;
    cyc();
    n_cmp++; if (bus.gnt !== 4'b0000 || wr_cnt !== cnt0 + 2) begin n_bad++; $display("FAIL rstg_end: gnt=%b writes=%0d want 0000/%0d", bus.gnt, wr_cnt, cnt0 + 2); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_pointer_wrap();
    test_addr_err();
    test_reset_in_gnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares a bank of N_REGS external Register instances between N_REQ write requesters.
- Arbitrates requests round-robin and drives a one-hot write enable plus a shared data bus to the bank.
- At most one register write per two cycles.
- Sits between producer blocks and the register bank; the bank's q outputs are read directly by consumers and do not pass through this block.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- N_REGS, 4, number of registers in the bank (1..16); AW = max(1, $clog2(N_REGS)).
- WIDTH, 4, register data width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester write request; level, held until granted.
- wr_addr  in  N_REQ*AW  per-requester target register index; requester i occupies bits [i*AW +: AW].
- wr_data  in  N_REQ*WIDTH  per-requester write data; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot grant pulse, one cycle long.
- reg_en  out  N_REGS  one-hot enable to the bank; connects to each Register en.
- reg_d  out  WIDTH  shared data bus to every Register d.
- busy  out  1  high while in state GNT.
- addr_err  out  1  one-cycle pulse when a granted address is >= N_REGS.

Behaviour:
- Reset values (rst high at an edge): state=ARB, gnt=0, reg_en=0, reg_d=0, busy=0, addr_err=0, rr_ptr=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- FSM, two states:
  - ARB: if req==0, stay in ARB with all pulse outputs 0. Otherwise choose the winner w as the first asserted req at or after rr_ptr, scanning upward and wrapping at N_REQ-1 to 0. At the edge, go to GNT and register:
    - gnt = 1<<w
    - reg_d = wr_data[w]
    - reg_en = 1<<wr_addr[w] if wr_addr[w] < N_REGS; otherwise reg_en=0 and addr_err=1
    - rr_ptr = (w+1) mod N_REQ
    - busy = 1
  - GNT: outputs hold their registered values for exactly this one cycle. req is ignored. At the edge, go to ARB and clear gnt, reg_en, addr_err and busy. reg_d holds its last value.
- Latency:
  - req first sampled at edge k → gnt/reg_en high during cycle k..k+1.
  - The bank captures reg_d at edge k+1.
  - New q is visible after edge k+1.
- Requester handshake:
  - Hold req, wr_addr and wr_data stable until gnt is seen high.
  - Deassert req, or present the next transaction, at the edge that ends the gnt cycle.
  - A requester that keeps req high after its grant is treated as a new request; this is legal back-to-back.
- Throughput: one write per 2 cycles. A requester with req held continuously receives at most one grant per N_REQ writes while others are requesting.
- Fairness: rr_ptr advances only on a grant. With a single active requester it is granted every 2 cycles.
- Simultaneous requests: resolved strictly by rr_ptr, not by index priority.
- Reset mid-operation: rst in state GNT returns to ARB with reg_en=0 at that edge. The pending write is not repeated.
- Reg_en invariant: at most one bit set, never set in state ARB, and equal to 0 whenever gnt==0.

Test Plan:
- Reset: hold rst 2 cycles with req=4'b1111 → gnt=0, reg_en=0, reg_d=0, busy=0 throughout; first grant after release goes to req0.
- Single write: req=4'b0100, wr_addr[2]=3, wr_data[2]=4'h9 → next cycle gnt=4'b0100, reg_en=4'b1000, reg_d=9, busy=1; the following cycle all pulse outputs return to 0; bank register 3 reads 9.
- Round-robin: req=4'b1111 held, addr_i=i, data_i=i+1 → grants in order 0,1,2,3,0 every 2 cycles; registers 0..3 = 1,2,3,4.
- Fairness with pointer wrap: rr_ptr=3 after a grant to 2; req=4'b1001 → req3 granted, then req0.
- Address error: N_REGS=3, wr_addr=3 → gnt pulses, reg_en=0, addr_err=1 for one cycle; no register changes.
- Reset in GNT: assert rst during the gnt cycle of a write → state=ARB and reg_en=0 next cycle; request still held is re-granted cleanly after rst drops; exactly one write is observed.
